// File: rtl/masked_pg_gen.sv
// masked_pg_gen: first-order masked propagate/generate generation for a
// Boolean-masked parallel-prefix adder. Propagate is share-local XOR; generate
// is a two-stage DOM-AND whose cross terms are refreshed with i_r and
// registered before any recombination.
//
// Handshake (both ports): a beat transfers on a rising edge where valid and
// ready are both high. Valid never depends on ready of the same port. Once
// o_valid is high, the output beat stays stable until i_ready takes it.
// Internally, stage 2 advances when empty or drained (en2 = !v2 | i_ready).
// Stage 1 advances when empty or when stage 2 advances (en1 = !v1 | en2),
// and o_ready = en1. A full pipe therefore shifts without a bubble.
module masked_pg_gen #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_a0,
    input  logic [W-1:0] i_a1,
    input  logic [W-1:0] i_b0,
    input  logic [W-1:0] i_b1,
    input  logic [W-1:0] i_r,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_p0,
    output logic [W-1:0] o_p1,
    output logic [W-1:0] o_g0,
    output logic [W-1:0] o_g1,
    output logic         o_valid,
    input  logic         i_ready
);

    // Pipeline occupancy and stage enables
    logic v1;
    logic v2;
    logic en1;
    logic en2;

    // Stage-1 registers: propagate shares plus the four DOM-AND terms.
    // Cross terms stay separate so share 0 and share 1 only meet after
    // the masking by i_r has been registered.
    logic [W-1:0] s1_p0;
    logic [W-1:0] s1_p1;
    logic [W-1:0] s1_in0;
    logic [W-1:0] s1_in1;
    logic [W-1:0] s1_cr0;
    logic [W-1:0] s1_cr1;

    // Stage-1 data load: only on an accepted beat
    logic ld1;
    // Stage-2 data load: only when stage 2 advances and stage 1 holds a beat
    logic ld2;

    assign en2     = !v2 || i_ready;
    assign en1     = !v1 || en2;
    assign o_ready = en1;
    assign o_valid = v2;
    assign ld1     = en1 && i_valid;
    assign ld2     = en2 && v1;

    // Valid bits: stage 1 samples i_valid on en1, stage 2 samples v1 on en2
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (en1) begin
                v1 <= i_valid;
            end
            if (en2) begin
                v2 <= v1;
            end
        end
    end

    // Stage 1: share-local propagate, inner products and r-masked cross products
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_p0  <= '0;
            s1_p1  <= '0;
            s1_in0 <= '0;
            s1_in1 <= '0;
            s1_cr0 <= '0;
            s1_cr1 <= '0;
        end else if (ld1) begin
            s1_p0  <= i_a0 ^ i_b0;
            s1_p1  <= i_a1 ^ i_b1;
            s1_in0 <= i_a0 & i_b0;
            s1_in1 <= i_a1 & i_b1;
            s1_cr0 <= (i_a0 & i_b1) ^ i_r;
            s1_cr1 <= (i_a1 & i_b0) ^ i_r;
        end
    end

    // Stage 2: DOM-AND recombination, propagate shares travel alongside
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_p0 <= '0;
            o_p1 <= '0;
            o_g0 <= '0;
            o_g1 <= '0;
        end else if (ld2) begin
            o_p0 <= s1_p0;
            o_p1 <= s1_p1;
            o_g0 <= s1_in0 ^ s1_cr0;
            o_g1 <= s1_in1 ^ s1_cr1;
        end
    end

endmodule

// File: tb/tb_masked_pg_gen.sv
// tb_masked_pg_gen: scoreboard bench for masked_pg_gen. Expected unmasked
// (p, g) pairs are queued when a beat is accepted and compared in order when
// the DUT hands a beat downstream; directed checks cover reset, latency,
// backpressure, mid-stream reset, mask independence and bubbles.
module tb_masked_pg_gen;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst;
    logic [W-1:0] i_a0;
    logic [W-1:0] i_a1;
    logic [W-1:0] i_b0;
    logic [W-1:0] i_b1;
    logic [W-1:0] i_r;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] o_p0;
    logic [W-1:0] o_p1;
    logic [W-1:0] o_g0;
    logic [W-1:0] o_g1;
    logic         o_valid;
    logic         i_ready;

    masked_pg_gen #(.W(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_a0    (i_a0),
        .i_a1    (i_a1),
        .i_b0    (i_b0),
        .i_b1    (i_b1),
        .i_r     (i_r),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_p0    (o_p0),
        .o_p1    (o_p1),
        .o_g0    (o_g0),
        .o_g1    (o_g1),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] exp_q[$];

    logic         mask_on = 1'b0;
    logic         mask_seen = 1'b0;
    logic [3:0]   mask_chg = 4'b0;
    logic [W-1:0] first_p0, first_p1, first_g0, first_g1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample away from the active edge; a transfer happens at the next posedge
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_nonempty", exp_q.size(), 1);
                end else begin
                    logic [2*W-1:0] e;
                    e = exp_q.pop_front();
                    check_eq("sb_p", {24'b0, o_p0 ^ o_p1}, {24'b0, e[2*W-1:W]});
                    check_eq("sb_g", {24'b0, o_g0 ^ o_g1}, {24'b0, e[W-1:0]});
                end
                if (mask_on) begin
                    check_eq("mask_p", {24'b0, o_p0 ^ o_p1}, 32'h66);
                    check_eq("mask_g", {24'b0, o_g0 ^ o_g1}, 32'h18);
                    if (!mask_seen) begin
                        mask_seen = 1'b1;
                        first_p0  = o_p0;
                        first_p1  = o_p1;
                        first_g0  = o_g0;
                        first_g1  = o_g1;
                    end else begin
                        if (o_p0 != first_p0) mask_chg[0] = 1'b1;
                        if (o_p1 != first_p1) mask_chg[1] = 1'b1;
                        if (o_g0 != first_g0) mask_chg[2] = 1'b1;
                        if (o_g1 != first_g1) mask_chg[3] = 1'b1;
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back({(i_a0 ^ i_a1) ^ (i_b0 ^ i_b1), (i_a0 ^ i_a1) & (i_b0 ^ i_b1)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_beat(input logic [W-1:0] a0, input logic [W-1:0] a1,
                              input logic [W-1:0] b0, input logic [W-1:0] b1,
                              input logic [W-1:0] r);
        i_a0    = a0;
        i_a1    = a1;
        i_b0    = b0;
        i_b1    = b1;
        i_r     = r;
        i_valid = 1'b1;
    endtask

    task automatic drive_rand();
        drive_beat(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   W'($urandom_range(0, 255)));
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            next_cycle();
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [4*W-1:0] snap;
    logic           hist[0:19];

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a0 = '0; i_a1 = '0; i_b0 = '0; i_b1 = '0; i_r = '0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_ready", o_ready, 1);
        check_eq("rst_data", {o_p0, o_p1, o_g0, o_g1}, 0);

        // Basic beat, accepted on the first edge after reset release
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        drive_beat(8'hFF, 8'hA5, 8'h0F, 8'h33, 8'h96);
        @(negedge i_clk);
        check_eq("basic_ready", o_ready, 1);
        next_cycle();
        idle();
        @(negedge i_clk);
        check_eq("basic_early", o_valid, 0);
        next_cycle();
        @(negedge i_clk);
        check_eq("basic_valid", o_valid, 1);
        check_eq("basic_p0", o_p0, 8'hF0);
        check_eq("basic_p1", o_p1, 8'h96);
        check_eq("basic_g0", o_g0, 8'hAA);
        check_eq("basic_g1", o_g1, 8'hB2);
        check_eq("basic_p", o_p0 ^ o_p1, 8'h66);
        check_eq("basic_g", o_g0 ^ o_g1, 8'h18);
        next_cycle();
        @(negedge i_clk);
        check_eq("basic_single", o_valid, 0);
        drain("basic_drain");

        // Streaming: 256 back-to-back beats
        for (int i = 0; i < 256; i++) begin
            next_cycle();
            drive_rand();
            @(negedge i_clk);
            if (i >= 2) check_eq("stream_valid", o_valid, 1);
        end
        next_cycle();
        idle();
        drain("stream_drain");

        // Backpressure: fill the pipe while stalled, then hold 5 cycles
        next_cycle();
        i_ready = 1'b0;
        drive_rand();
        next_cycle();
        drive_rand();
        next_cycle();
        drive_rand();
        @(negedge i_clk);
        check_eq("bp_ready", o_ready, 0);
        check_eq("bp_valid", o_valid, 1);
        snap = {o_p0, o_p1, o_g0, o_g1};
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive_rand();
            @(negedge i_clk);
            check_eq("bp_hold_ready", o_ready, 0);
            check_eq("bp_hold_data", {o_p0, o_p1, o_g0, o_g1}, snap);
        end
        next_cycle();
        idle();
        i_ready = 1'b1;
        drain("bp_drain");
        repeat (3) next_cycle();
        check_eq("bp_no_dup", o_valid, 0);

        // Reset mid-stream with two beats in flight
        next_cycle();
        drive_rand();
        next_cycle();
        drive_rand();
        next_cycle();
        idle();
        #1;
        i_rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("mrst_valid", o_valid, 0);
        check_eq("mrst_ready", o_ready, 1);
        check_eq("mrst_data", {o_p0, o_p1, o_g0, o_g1}, 0);
        next_cycle();
        i_rst = 1'b0;
        drive_beat(8'h3C, 8'hC3, 8'h55, 8'h0F, 8'h77);
        @(negedge i_clk);
        check_eq("mrst_no_partial", o_valid, 0);
        next_cycle();
        idle();
        @(negedge i_clk);
        check_eq("mrst_early", o_valid, 0);
        next_cycle();
        @(negedge i_clk);
        check_eq("mrst_valid_out", o_valid, 1);
        check_eq("mrst_p", o_p0 ^ o_p1, 8'hFF ^ 8'h5A);
        check_eq("mrst_g", o_g0 ^ o_g1, 8'hFF & 8'h5A);
        drain("mrst_drain");

        // Mask independence: A=0x5A, B=0x3C with fresh shares and r every beat
        mask_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a0, b0;
            next_cycle();
            a0 = W'($urandom_range(0, 255));
            b0 = W'($urandom_range(0, 255));
            drive_beat(a0, a0 ^ 8'h5A, b0, b0 ^ 8'h3C, W'($urandom_range(0, 255)));
        end
        next_cycle();
        idle();
        drain("mask_drain");
        mask_on = 1'b0;
        check_eq("mask_var_p0", mask_chg[0], 1);
        check_eq("mask_var_p1", mask_chg[1], 1);
        check_eq("mask_var_g0", mask_chg[2], 1);
        check_eq("mask_var_g1", mask_chg[3], 1);

        // Bubbles: o_valid mirrors i_valid two cycles later
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            if (i % 2 == 0) begin
                drive_rand();
                hist[i] = 1'b1;
            end else begin
                idle();
                hist[i] = 1'b0;
            end
            @(negedge i_clk);
            check_eq("bubble_valid", o_valid, (i >= 2) ? hist[i-2] : 1'b0);
        end
        next_cycle();
        idle();
        drain("bubble_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
